// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO/UART controller: register offsets,
// status bit positions and the status word builder.
package mmio_pkg;

  localparam logic [7:0] MMIO_STATUS = 8'h00;
  localparam logic [7:0] MMIO_RX     = 8'h04;
  localparam logic [7:0] MMIO_TX     = 8'h08;
  localparam logic [7:0] MMIO_CYC    = 8'h10;
  localparam logic [7:0] MMIO_INST   = 8'h14;
  localparam logic [7:0] MMIO_CRST   = 8'h18;

  localparam int STAT_TX_EMPTY    = 0;
  localparam int STAT_RX_NONEMPTY = 1;

  function automatic logic [31:0] status_word(input logic tx_empty, input logic rx_nonempty);
    logic [31:0] w;
    w = 32'h0000_0000;
    w[STAT_TX_EMPTY]    = tx_empty;
    w[STAT_RX_NONEMPTY] = rx_nonempty;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head output; push is ignored when
// full and pop is ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_en_s;
  logic             pop_en_s;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign dout      = mem_q[rd_ptr_q];
  assign push_en_s = push & ~full;
  assign pop_en_s  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en_s) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_en_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_en_s, pop_en_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mmio_uart_ctrl.sv
// Memory-mapped UART controller: decodes X-stage I/O accesses, returns load
// data one cycle later, buffers RX bytes, holds one TX byte, counts cycles/insts.
module mmio_uart_ctrl
  import mmio_pkg::*;
#(
  parameter int RX_DEPTH = 8,
  parameter int CNT_W    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        inst_retire,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready
);

  logic [31:0]      rdata_q, rdata_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] inst_q, inst_d;

  logic       sel_s;
  logic [7:0] off_s;
  logic       rd_s;
  logic       tx_empty_s;
  logic       tx_wr_s;
  logic       crst_s;
  logic       rx_push_s;
  logic       rx_pop_s;
  logic [7:0] rx_head_s;
  logic       rx_full_s;
  logic       rx_empty_s;
  logic       unused_s;

  assign sel_s      = addr[31];
  assign off_s      = addr[7:0];
  assign rd_s       = sel_s & re;
  assign tx_empty_s = ~tx_valid_q;
  assign tx_wr_s    = sel_s & we & (off_s == MMIO_TX);
  assign crst_s     = sel_s & we & (off_s == MMIO_CRST);
  assign rx_push_s  = uart_rx_valid & ~rx_full_s;
  assign rx_pop_s   = rd_s & (off_s == MMIO_RX) & ~rx_empty_s;
  assign unused_s   = ^{addr[30:8], wdata[31:8]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push_s),
    .pop   (rx_pop_s),
    .din   (uart_rx_data),
    .dout  (rx_head_s),
    .full  (rx_full_s),
    .empty (rx_empty_s)
  );

  // TX accept uses tx_empty before the handshake, so a write racing the
  // handshake is dropped; counter clear wins over the same-cycle increment.
  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    cyc_d      = cyc_q;
    inst_d     = inst_q;
    if (tx_wr_s && tx_empty_s) begin
      tx_valid_d = 1'b1;
      tx_data_d  = wdata[7:0];
    end else if (tx_valid_q && uart_tx_ready) begin
      tx_valid_d = 1'b0;
    end else begin
      tx_valid_d = tx_valid_q;
    end
    if (crst_s) begin
      cyc_d  = '0;
      inst_d = '0;
    end else begin
      cyc_d  = cyc_q + CNT_W'(1);
      inst_d = inst_q + CNT_W'(inst_retire);
    end
  end

  always_comb begin
    rdata_d = 32'h0000_0000;
    if (rd_s) begin
      case (off_s)
        MMIO_STATUS: rdata_d = status_word(tx_empty_s, ~rx_empty_s);
        MMIO_RX:     rdata_d = rx_empty_s ? 32'h0000_0000 : {24'h00_0000, rx_head_s};
        MMIO_CYC:    rdata_d = 32'(cyc_q);
        MMIO_INST:   rdata_d = 32'(inst_q);
        default:     rdata_d = 32'h0000_0000;
      endcase
    end else begin
      rdata_d = 32'h0000_0000;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q    <= 32'h0000_0000;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      cyc_q      <= '0;
      inst_q     <= '0;
    end else begin
      rdata_q    <= rdata_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      cyc_q      <= cyc_d;
      inst_q     <= inst_d;
    end
  end

  assign rdata         = rdata_q;
  assign uart_tx_valid = tx_valid_q;
  assign uart_tx_data  = tx_data_q;
  assign uart_rx_ready = ~rx_full_s;

endmodule

// File: doc/mmio_uart_ctrl.md
Name: mmio_uart_ctrl

Overview:
- Memory-mapped I/O controller between the CPU memory stage and the on-chip UART.
- Decodes I/O addresses (addr[31]=1) presented in the execute stage and returns read data one cycle later, matching dmem timing for the MW-stage writeback mux.
- Buffers received bytes in an RX FIFO, holds one TX byte for the transmitter handshake, and maintains cycle and retired-instruction counters.

Parameters:
- RX_DEPTH, 8, RX FIFO depth in bytes; power of 2, minimum 2.
- CNT_W, 32, width of the cycle and instruction counters; wraps modulo 2^CNT_W.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- addr  input  32  byte address from the ALU (X stage)
- re  input  1  load request this cycle
- we  input  1  store request this cycle
- wdata  input  32  store data; only [7:0] used for TX
- rdata  output  32  registered load data, valid the cycle after re
- inst_retire  input  1  pulse: one instruction committed this cycle
- uart_rx_data  input  8  byte from UART receiver
- uart_rx_valid  input  1  receiver byte valid
- uart_rx_ready  output  1  controller accepts RX byte
- uart_tx_data  output  8  byte to UART transmitter
- uart_tx_valid  output  1  TX byte valid
- uart_tx_ready  input  1  transmitter accepts byte

Behaviour:
- Select: sel = addr[31]. re/we are ignored when sel=0. Register offset is addr[7:0].
- Register map:
  - 0x00 status (RO): bit0 = tx_empty, bit1 = rx_nonempty, other bits 0.
  - 0x04 rx_data (RO, pops FIFO).
  - 0x08 tx_data (WO).
  - 0x10 cycle_cnt (RO).
  - 0x14 inst_cnt (RO).
  - 0x18 cnt_reset (WO, data ignored).
- Reset (async): rdata=0, uart_tx_valid=0, uart_tx_data=0, FIFO empty, both counters 0. uart_rx_ready=1 during and after reset, because it is combinational !full.
- Read latency is 1 cycle. rdata is registered on every clk:
  - sel&re to a readable offset: the value as of that cycle.
  - Otherwise (no read, unmapped, or write-only offset): 0.
- RX FIFO:
  - Push when uart_rx_valid & uart_rx_ready.
  - Pop when sel&re at 0x04 and FIFO non-empty; rdata = {24'b0, head byte}.
  - Read of 0x04 when empty: rdata=0, no pop, pointers unchanged.
  - When full, uart_rx_ready=0 and no push occurs; the receiver holds the byte.
  - Simultaneous push and pop when non-empty and not full: both take effect, count unchanged.
  - Pointers wrap modulo RX_DEPTH; count is held to 0..RX_DEPTH.
- TX holding register:
  - sel&we at 0x08 while tx_empty: latch wdata[7:0]; uart_tx_valid=1 from the next cycle.
  - uart_tx_valid & uart_tx_ready clears valid the next cycle.
  - Write while full: dropped silently; the held byte is unchanged.
  - A write in the same cycle as the handshake completes is dropped, because tx_empty is evaluated before the handshake.
  - tx_empty = !uart_tx_valid.
- Counters:
  - cycle_cnt increments every cycle out of reset.
  - inst_cnt increments on inst_retire.
  - sel&we at 0x18 forces both counters to 0 at the next edge; the increment in that cycle is discarded.
  - A read of a counter in the same cycle as cnt_reset returns the pre-clear value.
- Load and store in the same cycle: both take effect independently, including the same offset.
- Writes to read-only or unmapped offsets have no effect.
- Reset mid-operation: a pending TX byte is discarded, FIFO contents are lost, and any in-flight rdata is zeroed immediately.

Decomposition:
- Package mmio_pkg holds:
  - Offset localparams: MMIO_STATUS, MMIO_RX, MMIO_TX, MMIO_CYC, MMIO_INST, MMIO_CRST.
  - Status bit indices.
- One sub-module, sync_fifo:
  - Parameters: WIDTH, DEPTH.
  - Ports: clk/rst, push, pop, din, dout (combinational head), full, empty.
  - Used for RX.
- Counters, TX holding register and read mux stay in the top module.

Test Plan:
- Reset, then idle 5 cycles, then read 0x80000010: rdata = 5 (±fixed offset documented by the bench); status read returns 0x1; uart_rx_ready=1.
- Push bytes 0x41, 0x42, 0x43; read 0x80000004 three times: rdata 0x41, 0x42, 0x43, each the cycle after re. A fourth read returns 0, and status bit1=0.
- Push 9 bytes with RX_DEPTH=8: uart_rx_ready drops after the 8th push, and the 9th byte is held. One pop, then the 9th is accepted the next cycle with count = 8.
- Write 0x5A to 0x80000008 with uart_tx_ready=0: uart_tx_valid=1, data=0x5A. A second write of 0x77 is dropped. Raising ready for one cycle clears valid, and status bit0 returns to 1.
- Pulse inst_retire 4 times, then write 0x80000018 with a simultaneous read of 0x80000014: rdata=4. Next-cycle reads show both counters cleared and restarting.
- Assert rst asynchronously with TX valid and FIFO holding 3 bytes: uart_tx_valid=0, rdata=0 and FIFO empty immediately, without a clock edge.
